// File: rtl/mult_seq_signed_if.sv
//==============================================================================
// Module   : mult_seq_signed_if
// Purpose  : Handshake/operand bundle for the sequential signed multiplier.
//            The uns field exists only when MULT_SEQ_UNSIGNED_EN is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mult_seq_signed_if #(
    parameter int WIDTH = 8
) ();
    logic                 start;
    logic [WIDTH-1:0]     ra;
    logic [WIDTH-1:0]     rb;
`ifdef MULT_SEQ_UNSIGNED_EN
    logic                 uns;
`endif
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   res;
    logic [7:0]           flags;

`ifdef MULT_SEQ_UNSIGNED_EN
    modport master (output start, ra, rb, uns, input busy, done, res, flags);
    modport slave  (input start, ra, rb, uns, output busy, done, res, flags);
`else
    modport master (output start, ra, rb, input busy, done, res, flags);
    modport slave  (input start, ra, rb, output busy, done, res, flags);
`endif
endinterface

`default_nettype wire

// File: rtl/mult_seq_signed.sv
//==============================================================================
// Module   : mult_seq_signed
// Purpose  : WIDTH-bit two's-complement sequential multiplier (radix-2
//            shift-add on magnitudes, then sign correction), start/busy/done.
//            Optional unsigned mode: define MULT_SEQ_UNSIGNED_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mult_seq_signed #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mult_seq_signed_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_mcand;
    logic [2*WIDTH-1:0]     r_acc;
    logic                   r_sign;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_res;
    logic [7:0]             r_flags;
`ifdef MULT_SEQ_UNSIGNED_EN
    logic                   r_uns;
`endif

    logic                   w_uns_in;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic                   w_sign_in;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_step;
    logic [2*WIDTH-1:0]     w_res_next;
    logic [WIDTH:0]         w_hi;
    logic                   w_zf;
    logic                   w_nf;
    logic                   w_of;
    logic [7:0]             w_flags;

`ifdef MULT_SEQ_UNSIGNED_EN
    assign w_uns_in = bus.uns;
`else
    assign w_uns_in = 1'b0;
`endif

    // Magnitude of the most negative value is 2^(W-1), which still fits unsigned.
    assign w_mag_a   = (bus.ra[WIDTH-1] && !w_uns_in) ? (~bus.ra + 1'b1) : bus.ra;
    assign w_mag_b   = (bus.rb[WIDTH-1] && !w_uns_in) ? (~bus.rb + 1'b1) : bus.rb;
    assign w_sign_in = (bus.ra[WIDTH-1] ^ bus.rb[WIDTH-1]) & ~w_uns_in;

    // Upper half accumulates; lower half holds the multiplier being shifted out.
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    assign w_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                             : {1'b0, r_acc[2*WIDTH-1:1]};

    assign w_res_next = r_sign ? (~r_acc + 1'b1) : r_acc;

    assign w_hi = w_res_next[2*WIDTH-1:WIDTH-1];
    assign w_zf = (w_res_next == '0);
`ifdef MULT_SEQ_UNSIGNED_EN
    assign w_nf = r_uns ? 1'b0 : w_res_next[2*WIDTH-1];
    assign w_of = r_uns ? (|w_res_next[2*WIDTH-1:WIDTH])
                        : ~((&w_hi) | ~(|w_hi));
`else
    assign w_nf = w_res_next[2*WIDTH-1];
    assign w_of = ~((&w_hi) | ~(|w_hi));
`endif
    assign w_flags = {4'b0000, w_nf, w_of, 1'b0, w_zf};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_sign  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= '0;
            r_flags <= 8'h01;
`ifdef MULT_SEQ_UNSIGNED_EN
            r_uns   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mcand <= w_mag_a;
                        r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                        r_sign  <= w_sign_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef MULT_SEQ_UNSIGNED_EN
                        r_uns   <= bus.uns;
`endif
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    r_res   <= w_res_next;
                    r_flags <= w_flags;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.res   = r_res;
    assign bus.flags = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_signed.sv
//==============================================================================
// Module   : tb_mult_seq_signed
// Purpose  : Scoreboard bench for mult_seq_signed (WIDTH=8).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mult_seq_signed;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] res;
        logic [7:0]     flags;
        int             cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_seq_signed_if #(.WIDTH(W)) bus ();

    mult_seq_signed #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
        exp_t   e;
        longint p;
        logic   nf, of, zf;
        if (u) p = longint'({1'b0, a}) * longint'({1'b0, b});
        else   p = longint'($signed(a)) * longint'($signed(b));
        e.res = p[2*W-1:0];
        zf    = (p == 0);
        nf    = u ? 1'b0 : (p < 0);
        of    = u ? (p >= (longint'(1) << W))
                  : ((p < -(longint'(1) << (W-1))) || (p > ((longint'(1) << (W-1)) - 1)));
        e.flags = {4'b0000, nf, of, 1'b0, zf};
        e.cyc   = 0;
        return e;
    endfunction

    task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
        bus.start = 1'b1;
        bus.ra    = a;
        bus.rb    = b;
`ifdef MULT_SEQ_UNSIGNED_EN
        bus.uns   = u;
`endif
    endtask

    // Pulse start for one edge; push an expectation only when it should be taken.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic u, input bit accept);
        exp_t e;
        @(negedge clk);
        drive_ops(a, b, u);
        if (accept) begin
            e = model(a, b, u);
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.ra    = W'($urandom);
        bus.rb    = W'($urandom);
        if (accept) chk("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'(bus.done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res", 64'(bus.res), 64'(e.res));
                    chk("flags", 64'(bus.flags), 64'(e.flags));
                    chk("latency", 64'(cyc - e.cyc), 64'(W + 1));
                    chk("busy_in_done", 64'(bus.busy), 64'd0);
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus.start = 1'b0;
        bus.ra    = '0;
        bus.rb    = '0;
`ifdef MULT_SEQ_UNSIGNED_EN
        bus.uns   = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_res", 64'(bus.res), 64'd0);
        chk("rst_flags", 64'(bus.flags), 64'h01);
        rst = 1'b0;

        launch(8'd3, 8'hFB, 1'b0, 1'b1);    drain();
        launch(8'h80, 8'h80, 1'b0, 1'b1);   drain();
        launch(8'd127, 8'd127, 1'b0, 1'b1); drain();
        launch(8'd0, 8'hF9, 1'b0, 1'b1);    drain();
        launch(8'h80, 8'd127, 1'b0, 1'b1);  drain();
        launch(8'h80, 8'd1, 1'b0, 1'b1);    drain();

        // Start while busy is ignored; start in the done cycle runs back-to-back.
        launch(8'd5, 8'd6, 1'b0, 1'b1);
        launch(8'd2, 8'd2, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
        chk("b2b_done_seen", 64'(bus.done), 64'd1);
        drive_ops(8'hFF, 8'd1, 1'b0);
        e = model(8'hFF, 8'd1, 1'b0);
        e.cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        drain();

        // Abort mid-operation: no done may follow.
        launch(8'd3, 8'd3, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_res", 64'(bus.res), 64'd0);
        chk("abort_flags", 64'(bus.flags), 64'h01);
        repeat (15) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            launch(W'($urandom), W'($urandom), 1'b0, 1'b1);
            drain();
        end

`ifdef MULT_SEQ_UNSIGNED_EN
        launch(8'hFF, 8'h02, 1'b1, 1'b1); drain();
        launch(8'h0F, 8'h0F, 1'b1, 1'b1); drain();
        launch(8'hFF, 8'h02, 1'b0, 1'b1); drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_seq_signed.md
Name: mult_seq_signed

Overview:
- Parametrised sequential multiplier for the ALU's multiply path. Supersedes the fixed 4-bit combinational sign-magnitude multiplier.
- Takes two WIDTH-bit two's-complement operands. Computes a full 2*WIDTH-bit product with a radix-2 shift-add engine over WIDTH cycles, then applies sign correction.
- Uses a start/busy/done handshake.
- Flags byte uses the same packing as every other ALU unit, so the flag mux can select it directly.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- ra  input  WIDTH  multiplicand, two's complement; sampled with start
- rb  input  WIDTH  multiplier, two's complement; sampled with start
- busy  output  1  high while an operation is in progress (RUN or SIGN)
- done  output  1  one-cycle pulse; res/flags valid from this cycle on
- res  output  2*WIDTH  two's-complement product
- flags  output  8  {4'b0, NF, OF, CF, ZF}

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset values (rst high at an edge):
  - state=IDLE, busy=0, done=0, res=0, flags=8'h01 (ZF set, reflecting res=0).
  - Reset mid-operation aborts it; no done pulse is produced.
- State IDLE:
  - busy=0.
  - On an edge with start=1: latch |ra| and |rb| (WIDTH-bit unsigned magnitudes) and the result sign ra[W-1]^rb[W-1].
  - Clear the 2*WIDTH accumulator, set the iteration counter to 0, go to RUN.
- State RUN (WIDTH edges):
  - Each edge: if multiplier-magnitude LSB=1, add the multiplicand magnitude into the accumulator upper half with carry.
  - Then shift the accumulator/multiplier right by one and increment the counter.
  - After the WIDTH-th RUN edge, go to SIGN.
- State SIGN (one edge):
  - res <= sign ? -acc : acc (2*WIDTH two's complement).
  - flags are registered from the final res; done<=1; go to IDLE.
- Latency:
  - start sampled at edge E0; done=1 and res valid in the cycle after edge E(WIDTH+1).
  - Example: WIDTH=8 gives done 9 cycles after start.
- busy is 1 from after E0 through the SIGN edge; it is 0 in the done cycle.
- done is high for exactly one cycle.
- res and flags hold their values until the next SIGN edge or reset.
- start while busy=1 is ignored; it is not queued.
- start in the done cycle is legal: the state is IDLE, so the new operation begins back-to-back.
- Operands change freely after E0 without effect.
- Arithmetic:
  - |-2^(W-1)| = 2^(W-1), which fits in the WIDTH-bit unsigned magnitude.
  - The full product always fits in 2*WIDTH signed. Max case (-2^(W-1))^2 = 2^(2W-2).
  - A zero product is always +0; there is no negative zero, even if operand signs differ.
- Flags:
  - ZF = (res==0).
  - NF = res[2W-1].
  - CF = 0.
  - OF = 1 when the product lies outside the WIDTH-bit signed range [-2^(W-1), 2^(W-1)-1], i.e. res[2W-1:W-1] is not all equal.

Optional Feature:
- Macro MULT_SEQ_UNSIGNED_EN.
- When defined, an extra input `uns` (1 bit) is added and sampled with start:
  - uns=1 treats ra/rb as unsigned; magnitudes are the raw operands and sign=0.
  - Flags for an unsigned operation: NF=0, OF=1 iff res >= 2^WIDTH.
  - uns=0 behaves exactly as signed.
- When not defined, the port is absent and every operation is signed.

Test Plan:
- WIDTH=8, ra=3, rb=-5 (8'hFB), start pulse -> done 9 cycles later, res=16'hFFF1, flags=8'h08 (NF=1, OF=0, ZF=0).
- ra=-128, rb=-128 -> res=16'h4000, flags=8'h04 (OF=1). Then ra=127, rb=127 -> res=16'h3F01, flags=8'h04.
- ra=0, rb=-7 -> res=16'h0000, flags=8'h01 (ZF=1, NF=0; no negative zero).
- Start ra=5, rb=6; pulse start with ra=2, rb=2 at cycle 3 -> single done, res=16'h001E; second start ignored. Then start asserted in the done cycle with ra=-1, rb=1 -> next done 9 cycles later, res=16'hFFFF.
- Assert rst at cycle 4 of an operation -> next cycle busy=0, done=0, res=0, flags=8'h01; no done pulse follows.
- With MULT_SEQ_UNSIGNED_EN: uns=1, ra=8'hFF, rb=8'h02 -> res=16'h01FE, flags=8'h04 (OF=1, NF=0).
